move_chunker: RTL and testbench

MOVE_CHUNKER -- requirements
Module: move_chunker

---
 rtl/move_chunker.sv | 146 ++++++++++++++
 tb/tb_move_chunker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/move_chunker.sv
// Splits a signed XY move into per-axis chunks no larger than +/-MAXC and feeds
// them one at a time to an XY stepper controller, waiting for each to finish.
module move_chunker #(
    parameter int IN_BITS      = 16,
    parameter int OUT_BITS     = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_dx,
    input  logic [IN_BITS-1:0]  in_dy,
    output logic [OUT_BITS-1:0] num_steps_x,
    output logic [OUT_BITS-1:0] num_steps_y,
    output logic                trigger,
    input  logic                stepper_done,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] GUARD     = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] FINISH    = 3'd5;

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    // Symmetric limit keeps the most-negative OUT_BITS code out of the chunk stream.
    localparam logic signed [IN_BITS-1:0] MAXC = IN_BITS'((2 ** (OUT_BITS - 1)) - 1);

    function automatic logic signed [IN_BITS-1:0] clamp_chunk(input logic signed [IN_BITS-1:0] v);
        if (v > MAXC) begin
            clamp_chunk = MAXC;
        end else if (v < -MAXC) begin
            clamp_chunk = -MAXC;
        end else begin
            clamp_chunk = v;
        end
    endfunction

    logic [2:0]                 state_r, state_s;
    logic signed [IN_BITS-1:0]  rem_x_r, rem_x_s, rem_y_r, rem_y_s;
    logic signed [IN_BITS-1:0]  chunk_x_s, chunk_y_s;
    logic [OUT_BITS-1:0]        steps_x_r, steps_x_s, steps_y_r, steps_y_s;
    logic [GW-1:0]              guard_cnt_r, guard_cnt_s;
    logic                       trigger_r, done_r, busy_r, in_ready_r;

    assign chunk_x_s = clamp_chunk(rem_x_r);
    assign chunk_y_s = clamp_chunk(rem_y_r);

    // Next-state and datapath update for one enabled cycle.
    always_comb begin
        state_s     = state_r;
        rem_x_s     = rem_x_r;
        rem_y_s     = rem_y_r;
        steps_x_s   = steps_x_r;
        steps_y_s   = steps_y_r;
        guard_cnt_s = guard_cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    rem_x_s = $signed(in_dx);
                    rem_y_s = $signed(in_dy);
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if ((rem_x_r == '0) && (rem_y_r == '0)) begin
                    state_s = FINISH;
                end else begin
                    steps_x_s = chunk_x_s[OUT_BITS-1:0];
                    steps_y_s = chunk_y_s[OUT_BITS-1:0];
                    rem_x_s   = rem_x_r - chunk_x_s;
                    rem_y_s   = rem_y_r - chunk_y_s;
                    state_s   = ISSUE;
                end
            end
            ISSUE: begin
                guard_cnt_s = '0;
                state_s     = GUARD;
            end
            GUARD: begin
                if (guard_cnt_r == GUARD_LAST) begin
                    guard_cnt_s = '0;
                    state_s     = WAIT_DONE;
                end else begin
                    guard_cnt_s = guard_cnt_r + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (stepper_done) begin
                    state_s = LOAD;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rem_x_r     <= '0;
            rem_y_r     <= '0;
            steps_x_r   <= '0;
            steps_y_r   <= '0;
            guard_cnt_r <= '0;
            trigger_r   <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (clk_en) begin
            state_r     <= state_s;
            rem_x_r     <= rem_x_s;
            rem_y_r     <= rem_y_s;
            steps_x_r   <= steps_x_s;
            steps_y_r   <= steps_y_s;
            guard_cnt_r <= guard_cnt_s;
            trigger_r   <= (state_s == ISSUE);
            done_r      <= (state_s == FINISH);
            busy_r      <= (state_s != IDLE);
            in_ready_r  <= (state_s == IDLE);
        end
    end

    assign num_steps_x = steps_x_r;
    assign num_steps_y = steps_y_r;
    assign trigger     = trigger_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign in_ready    = in_ready_r;

endmodule

// File: tb/tb_move_chunker.sv
// Scoreboard bench for move_chunker: a reference chunker fills expected-chunk
// queues at handshake time; a monitor pops and compares on every trigger.
module tb_move_chunker;

    logic        clk = 1'b0;
    logic        reset, clk_en, in_valid, in_ready, trigger, stepper_done, busy, done;
    logic [15:0] in_dx, in_dy;
    logic [7:0]  num_steps_x, num_steps_y;

    int checks = 0;
    int failures = 0;
    int exp_x_q[$];
    int exp_y_q[$];
    int cyc = 0, hs_cyc = 0, trig_cnt = 0, prev_trig_cyc = -1, first_trig_cyc = 0;
    int done_cnt = 0, done_cyc = 0, sd_cnt = 0, exp_gap = 6, ph = 0;
    bit hold_mode = 1'b0;
    bit en_div = 1'b0;
    localparam int DELAY = 5;

    move_chunker #(.IN_BITS(16), .OUT_BITS(8), .GUARD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_dx(in_dx), .in_dy(in_dy), .num_steps_x(num_steps_x), .num_steps_y(num_steps_y),
        .trigger(trigger), .stepper_done(stepper_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > 127) return 127;
        else if (v < -127) return -127;
        else return v;
    endfunction

    task automatic load_model(input int dx, input int dy, output int n);
        int rx, ry, cx, cy;
        rx = dx; ry = dy; n = 0;
        while (rx != 0 || ry != 0) begin
            cx = clampi(rx); cy = clampi(ry);
            exp_x_q.push_back(cx); exp_y_q.push_back(cy);
            rx -= cx; ry -= cy; n++;
        end
    endtask

    // clk_en: always on, or one cycle in four
    initial begin
        clk_en = 1'b1;
        forever begin
            @(posedge clk); #1;
            clk_en = en_div ? (ph == 0) : 1'b1;
            ph = (ph + 1) % 4;
        end
    end

    // Monitor + stepper model, evaluated mid-cycle on enabled cycles
    initial begin
        stepper_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sd_cnt = 0;
                stepper_done = 1'b0;
            end else if (clk_en) begin
                cyc++;
                if (in_valid && in_ready) hs_cyc = cyc;
                if (trigger) begin
                    trig_cnt++;
                    if (trig_cnt == 1) first_trig_cyc = cyc;
                    if (exp_x_q.size() == 0) begin
                        check("trig_unexpected", 1, 0);
                    end else begin
                        check("chunk_x", int'($signed(num_steps_x)), exp_x_q.pop_front());
                        check("chunk_y", int'($signed(num_steps_y)), exp_y_q.pop_front());
                    end
                    check("no_min_x", int'(num_steps_x == 8'h80), 0);
                    check("no_min_y", int'(num_steps_y == 8'h80), 0);
                    if (prev_trig_cyc >= 0) check("trig_gap", cyc - prev_trig_cyc, exp_gap);
                    prev_trig_cyc = cyc;
                    sd_cnt = 1;
                    stepper_done = hold_mode;
                end else begin
                    if (sd_cnt > 0) sd_cnt++;
                    stepper_done = hold_mode || (sd_cnt == DELAY);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic handshake(input int dx, input int dy, output int n);
        int k;
        trig_cnt = 0; prev_trig_cyc = -1;
        load_model(dx, dy, n);
        k = 0;
        do begin @(posedge clk); #2; k++; end while (!(clk_en && in_ready) && k < 200);
        if (k >= 200) check("ready_timeout", 0, 1);
        in_dx = 16'(dx); in_dy = 16'(dy); in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic run_move(input int dx, input int dy, input bit div, input bit hold, input bit pulse_busy);
        int n, k, d0;
        en_div = div; hold_mode = hold; exp_gap = hold ? 5 : 6;
        d0 = done_cnt;
        handshake(dx, dy, n);
        if (pulse_busy) begin
            repeat (3) @(posedge clk);
            #2;
            in_dx = 16'sd7; in_dy = 16'sd7; in_valid = 1'b1;
            check("ready_busy", int'(in_ready), 0);
            check("busy_flag", int'(busy), 1);
            repeat (2) @(posedge clk);
            #2;
            in_valid = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 8000) begin @(posedge clk); #2; k++; end
        check("done_timeout", int'(done_cnt != d0), 1);
        check("ready_after", int'(in_ready), 1);
        check("busy_after", int'(busy), 0);
        check("done_low", int'(done), 0);
        if (n == 0) begin
            check("zero_done_lat", done_cyc - hs_cyc, 2);
        end else begin
            check("first_trig_lat", first_trig_cyc - hs_cyc, 2);
        end
        check("trig_count", trig_cnt, n);
        check("sb_empty", exp_x_q.size(), 0);
        repeat (8) @(posedge clk);
        #2;
        check("single_done", done_cnt - d0, 1);
        en_div = 1'b0; hold_mode = 1'b0;
    endtask

    task automatic reset_mid_move();
        int n, k, d0;
        en_div = 1'b0; hold_mode = 1'b0; exp_gap = 6;
        handshake(300, -50, n);
        k = 0;
        while (trig_cnt < 2 && k < 200) begin @(posedge clk); #2; k++; end
        check("second_trig_seen", trig_cnt, 2);
        repeat (2) @(posedge clk);
        #2;
        check("wait_busy", int'(busy), 1);
        check("wait_no_trig", int'(trigger), 0);
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #2;
        check("rst_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_trig", int'(trigger), 0);
        check("rst_done", int'(done), 0);
        check("rst_nsx", int'(num_steps_x), 0);
        check("rst_nsy", int'(num_steps_y), 0);
        reset = 1'b0;
        exp_x_q.delete(); exp_y_q.delete();
        repeat (12) @(posedge clk);
        #2;
        check("rst_no_done", done_cnt - d0, 0);
        run_move(10, -200, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_dx = '0; in_dy = '0;
        repeat (3) @(posedge clk);
        #2;
        check("init_ready", int'(in_ready), 1);
        check("init_busy", int'(busy), 0);
        check("init_trig", int'(trigger), 0);
        check("init_done", int'(done), 0);
        check("init_nsx", int'(num_steps_x), 0);
        reset = 1'b0;

        run_move(300, -50, 1'b0, 1'b0, 1'b0);
        run_move(0, 0, 1'b0, 1'b0, 1'b0);
        run_move(-32768, 5, 1'b0, 1'b0, 1'b0);
        run_move(300, -50, 1'b1, 1'b0, 1'b0);
        run_move(300, -50, 1'b0, 1'b1, 1'b1);
        reset_mid_move();
        run_move(-1, 255, 1'b1, 1'b0, 1'b0);
        run_move(127, -128, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_move(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500,
                     1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
